// File: rtl/thermo_tick_gen.sv
// Watches an upstream thermometer fill counter, restarts it, and emits a tick each time it saturates.
// Optional thermometer-validity checker is built when THERMO_TICK_ERR_CHECK_EN is defined.
module thermo_tick_gen #(
    parameter int WIDTH  = 32,
    parameter int LVL_W  = 6,
    parameter int TICK_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  fill,
    output logic              restart,
    output logic              tick,
    output logic [LVL_W-1:0]  level,
    output logic [TICK_W-1:0] tick_count,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        FILLING = 2'd2,
        FULL    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         clrCnt_q, clrCnt_d;
    logic [TICK_W-1:0]  tickCnt_q, tickCnt_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               restart_q, tick_q, busy_q;

    function automatic logic [LVL_W-1:0] popCount(input logic [WIDTH-1:0] v);
        logic [LVL_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + LVL_W'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        clrCnt_d  = clrCnt_q;
        tickCnt_d = tickCnt_q;
        level_d   = popCount(fill);
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = CLEAR;
                    clrCnt_d = 2'd0;
                end
            end
            // Upstream reset is held for two cycles regardless of enable.
            CLEAR: begin
                if (clrCnt_q == 2'd1) begin
                    state_d = FILLING;
                end else begin
                    clrCnt_d = clrCnt_q + 2'd1;
                end
            end
            FILLING: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (&fill) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                tickCnt_d = tickCnt_q + TICK_W'(1);
                clrCnt_d  = 2'd0;
                state_d   = enable ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so nothing from fill/enable reaches a port combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            clrCnt_q  <= 2'd0;
            tickCnt_q <= '0;
            level_q   <= '0;
            restart_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clrCnt_q  <= clrCnt_d;
            tickCnt_q <= tickCnt_d;
            level_q   <= level_d;
            restart_q <= (state_d == CLEAR);
            tick_q    <= (state_d == FULL);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign restart    = restart_q;
    assign tick       = tick_q;
    assign busy       = busy_q;
    assign level      = level_q;
    assign tick_count = tickCnt_q;

`ifdef THERMO_TICK_ERR_CHECK_EN
    logic err_q;
    logic thermoOk;

    // A valid word is 2^k-1: adding one clears every set bit.
    assign thermoOk = ((fill & (fill + WIDTH'(1))) == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state_q == FILLING) && !thermoOk) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_thermo_tick_gen.sv
// Directed bench for thermo_tick_gen: level table, free run with upstream model, abort, wrap, error and mid-run reset.
module tb_thermo_tick_gen;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        enable;
    logic        useOvr;
    logic [31:0] ovrVal;
    logic [31:0] modelA = '0;
    logic [31:0] modelB = '0;
    logic [31:0] fillA, fillB;

    logic        restartA, tickA, busyA, errA;
    logic [5:0]  levelA;
    logic [15:0] tickCountA;
    logic        restartB, tickB, busyB, errB;
    logic [5:0]  levelB;
    logic [1:0]  tickCountB;

    int errors = 0;
    int checks = 0;

    assign fillA = useOvr ? ovrVal : modelA;
    assign fillB = useOvr ? ovrVal : modelB;

    thermo_tick_gen #(.WIDTH(32), .LVL_W(6), .TICK_W(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .fill(fillA),
        .restart(restartA), .tick(tickA), .level(levelA),
        .tick_count(tickCountA), .busy(busyA), .err(errA)
    );

    thermo_tick_gen #(.WIDTH(32), .LVL_W(6), .TICK_W(2)) dutW (
        .clock(clock), .reset(reset), .enable(enable), .fill(fillB),
        .restart(restartB), .tick(tickB), .level(levelB),
        .tick_count(tickCountB), .busy(busyB), .err(errB)
    );

    // Behavioural upstream counters: clear on restart, otherwise shift a one in.
    always @(posedge clock) begin
        modelA <= (reset || restartA) ? 32'h0 : {modelA[30:0], 1'b1};
        modelB <= (reset || restartB) ? 32'h0 : {modelB[30:0], 1'b1};
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en);
        reset  = rst;
        enable = en;
        @(posedge clock);
        #1;
    endtask

    task automatic waitTick(input int budget, input string name);
        for (int i = 0; i < budget && !tickA; i++) applyStimulus(1'b0, 1'b1);
        checkOutput(name, tickA, 1);
    endtask

    typedef struct {
        logic [31:0] fillVal;
        logic [5:0]  expLevel;
    } vec_t;

    vec_t vecs[8];
    int   expWrap[5] = '{1, 2, 3, 0, 1};
    logic expErr;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ticksSeen;
        int lastTick;
        int restartRun;
        int badAbort;
        logic prevTick;

`ifdef THERMO_TICK_ERR_CHECK_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif

        vecs[0] = '{32'h0000_0000, 6'd0};
        vecs[1] = '{32'h0000_0001, 6'd1};
        vecs[2] = '{32'h0000_00FF, 6'd8};
        vecs[3] = '{32'hFFFF_FFFF, 6'd32};
        vecs[4] = '{32'h8000_0001, 6'd2};
        vecs[5] = '{32'hAAAA_AAAA, 6'd16};
        vecs[6] = '{32'h0000_0005, 6'd2};
        vecs[7] = '{32'h7FFF_FFFF, 6'd31};

        useOvr = 1'b1;
        ovrVal = 32'h0;
        reset  = 1'b1;
        enable = 1'b0;

        // Reset wins even with enable asserted.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset_busy", busyA, 0);
        checkOutput("reset_tick", tickA, 0);
        checkOutput("reset_restart", restartA, 0);
        checkOutput("reset_level", levelA, 0);
        checkOutput("reset_tick_count", tickCountA, 0);
        checkOutput("reset_err", errA, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("idle_busy", busyA, 0);
            checkOutput("idle_restart", restartA, 0);
            checkOutput("idle_tick", tickA, 0);
            checkOutput("idle_level", levelA, 0);
            checkOutput("idle_tick_count", tickCountA, 0);
        end

        for (int i = 0; i < 8; i++) begin
            ovrVal = vecs[i].fillVal;
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("vec%0d_level", i), levelA, vecs[i].expLevel);
            checkOutput($sformatf("vec%0d_busy", i), busyA, 0);
            checkOutput($sformatf("vec%0d_err", i), errA, 0);
        end

        // Free run: tick in the 36th busy cycle, then every 36 cycles with two restart cycles each.
        useOvr     = 1'b0;
        ticksSeen  = 0;
        lastTick   = 0;
        restartRun = 0;
        prevTick   = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            applyStimulus(1'b0, 1'b1);
            if (prevTick) begin
                checkOutput($sformatf("tick_count_after_%0d", ticksSeen), tickCountA, ticksSeen);
                checkOutput($sformatf("wrap_count_after_%0d", ticksSeen), tickCountB, expWrap[ticksSeen-1]);
                if (ticksSeen == 5) break;
            end
            if (n == 1) checkOutput("run_busy", busyA, 1);
            if (restartA) restartRun++;
            if (tickA) begin
                ticksSeen++;
                if (ticksSeen == 1) checkOutput("first_tick_cycle", n, 36);
                else checkOutput("tick_period", n - lastTick, 36);
                checkOutput("restart_cycles", restartRun, 2);
                restartRun = 0;
                lastTick   = n;
            end
            prevTick = tickA;
        end
        checkOutput("ticks_seen", ticksSeen, 5);

        // Abort mid-fill at level 10.
        for (int i = 0; i < 100 && levelA != 6'd10; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("abort_level_reached", levelA, 10);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_busy", busyA, 0);
        badAbort = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (tickA || restartA || busyA) badAbort++;
        end
        checkOutput("abort_quiet_cycles", badAbort, 0);
        checkOutput("abort_tick_count", tickCountA, 5);

        // Inject a non-thermometer word during FILLING.
        for (int i = 0; i < 100 && levelA != 6'd4; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("err_level_reached", levelA, 4);
        checkOutput("err_before", errA, 0);
        useOvr = 1'b1;
        ovrVal = 32'h0000_0005;
        applyStimulus(1'b0, 1'b1);
        useOvr = 1'b0;
        checkOutput("err_set", errA, expErr);
        waitTick(200, "err_tick1_seen");
        checkOutput("err_hold_tick1", errA, expErr);
        applyStimulus(1'b0, 1'b1);
        waitTick(200, "err_tick2_seen");
        checkOutput("err_hold_tick2", errA, expErr);
        applyStimulus(1'b0, 1'b1);

        // Reset while in FULL.
        waitTick(200, "full_before_reset");
        applyStimulus(1'b1, 1'b0);
        checkOutput("midreset_tick", tickA, 0);
        checkOutput("midreset_tick_count", tickCountA, 0);
        checkOutput("midreset_busy", busyA, 0);
        checkOutput("midreset_restart", restartA, 0);
        checkOutput("midreset_err", errA, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("after_reset_idle", busyA, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
